// File: rtl/dcache_miss_handler.sv
// Data-cache miss engine: optionally writes back a dirty victim line, refills the
// missing line beat by beat, then installs it into the cache with a single fill strobe.
module dcache_miss_handler #(
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned WordsPerLine = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              miss_req_i,
    input  logic [AddrWidth-1:0]              miss_addr_i,
    input  logic                              victim_dirty_i,
    input  logic [AddrWidth-1:0]              victim_addr_i,
    input  logic [DataWidth*WordsPerLine-1:0] victim_data_i,
    output logic                              stall_o,
    output logic                              mem_req_o,
    output logic                              mem_we_o,
    output logic [AddrWidth-1:0]              mem_addr_o,
    output logic [DataWidth-1:0]              mem_wdata_o,
    input  logic                              mem_ready_i,
    input  logic [DataWidth-1:0]              mem_rdata_i,
    output logic                              fill_valid_o,
    output logic [AddrWidth-1:0]              fill_addr_o,
    output logic [DataWidth*WordsPerLine-1:0] fill_data_o
);

    localparam int unsigned Off   = $clog2(WordsPerLine * 4);
    localparam int unsigned BeatW = $clog2(WordsPerLine);

    typedef enum logic [1:0] {StIdle, StWb, StRf, StFill} state_e;

    state_e                                   state_q, state_d;
    logic [BeatW-1:0]                         beat_q, beat_d;
    logic [AddrWidth-1:0]                     line_q, line_d;
    logic [AddrWidth-1:0]                     vaddr_q, vaddr_d;
    logic [WordsPerLine-1:0][DataWidth-1:0]   vdata_q, vdata_d;
    logic [WordsPerLine-1:0][DataWidth-1:0]   buf_q, buf_d;

    logic                 beat_done;
    logic                 last_beat;
    logic [AddrWidth-1:0] beat_off;

    // Offset bits of the miss address never matter: the refill always covers the whole line.
    logic unused_offset_bits;
    assign unused_offset_bits = ^miss_addr_i[Off-1:0];

    assign beat_done = mem_req_o & mem_ready_i;
    assign last_beat = (beat_q == BeatW'(WordsPerLine - 1));
    assign beat_off  = AddrWidth'({beat_q, 2'b00});
    assign stall_o   = miss_req_i | (state_q != StIdle);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        line_d  = line_q;
        vaddr_d = vaddr_q;
        vdata_d = vdata_q;
        buf_d   = buf_q;
        case (state_q)
            StIdle: begin
                if (miss_req_i) begin
                    line_d  = {miss_addr_i[AddrWidth-1:Off], {Off{1'b0}}};
                    vaddr_d = victim_addr_i;
                    vdata_d = victim_data_i;
                    beat_d  = '0;
                    state_d = victim_dirty_i ? StWb : StRf;
                end
            end
            StWb: begin
                if (beat_done) begin
                    beat_d = beat_q + BeatW'(1);
                    if (last_beat) begin
                        state_d = StRf;
                    end
                end
            end
            StRf: begin
                if (beat_done) begin
                    buf_d[beat_q] = mem_rdata_i;
                    beat_d        = beat_q + BeatW'(1);
                    if (last_beat) begin
                        state_d = StFill;
                    end
                end
            end
            StFill:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        fill_valid_o = 1'b0;
        fill_addr_o  = '0;
        fill_data_o  = '0;
        case (state_q)
            StWb: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = vaddr_q + beat_off;
                mem_wdata_o = vdata_q[beat_q];
            end
            StRf: begin
                mem_req_o  = 1'b1;
                mem_addr_o = line_q + beat_off;
            end
            StFill: begin
                fill_valid_o = 1'b1;
                fill_addr_o  = line_q;
                fill_data_o  = buf_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            beat_q  <= '0;
            line_q  <= '0;
            vaddr_q <= '0;
            vdata_q <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
            vaddr_q <= vaddr_d;
            vdata_q <= vdata_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: tb/tb_dcache_miss_handler.sv
// Scoreboard bench for dcache_miss_handler: stimulus queues expected beats and fills,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_dcache_miss_handler;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } beat_t;

    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
        logic [31:0]  cyc;
    } fill_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         miss_req;
    logic [31:0]  miss_addr;
    logic         victim_dirty;
    logic [31:0]  victim_addr;
    logic [127:0] victim_data;
    logic         stall;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_ready;
    logic [31:0]  mem_rdata;
    logic         fill_valid;
    logic [31:0]  fill_addr;
    logic [127:0] fill_data;

    int unsigned  cyc = 0;
    int           n_vec = 0;
    int           n_err = 0;
    beat_t        beat_exp[$];
    fill_t        fill_exp[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_rdata = mem_addr ^ 32'hA5A5_0000;

    dcache_miss_handler dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .miss_req_i     (miss_req),
        .miss_addr_i    (miss_addr),
        .victim_dirty_i (victim_dirty),
        .victim_addr_i  (victim_addr),
        .victim_data_i  (victim_data),
        .stall_o        (stall),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_ready_i    (mem_ready),
        .mem_rdata_i    (mem_rdata),
        .fill_valid_o   (fill_valid),
        .fill_addr_o    (fill_addr),
        .fill_data_o    (fill_data)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string msg);
        n_vec++;
        n_err++;
        $display("FAIL %s: %s", name, msg);
    endtask

    // Monitor: every accepted beat and every fill strobe is matched against the queues.
    initial begin
        logic  held;
        beat_t held_b;
        beat_t e;
        fill_t f;
        held = 1'b0;
        held_b = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("hold_stable", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, held_b});
                end
                held   = mem_req && !mem_ready;
                held_b = '{we: mem_we, addr: mem_addr, wdata: mem_wdata};
                if (mem_req && mem_ready) begin
                    if (beat_exp.size() == 0) begin
                        fail("extra_beat", $sformatf("got beat at %h, none expected", mem_addr));
                    end else begin
                        e = beat_exp.pop_front();
                        check("beat_addr", mem_addr, e.addr);
                        check("beat_we", mem_we, e.we);
                        if (e.we) check("beat_wdata", mem_wdata, e.wdata);
                    end
                end
                if (fill_valid) begin
                    if (fill_exp.size() == 0) begin
                        fail("extra_fill", $sformatf("got fill at %h, none expected", fill_addr));
                    end else begin
                        f = fill_exp.pop_front();
                        check("fill_addr", fill_addr, f.addr);
                        check("fill_data", fill_data, f.data);
                        check("fill_cycle", cyc, f.cyc);
                    end
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Called in the acceptance cycle; queues the full expected transaction.
    task automatic push_miss(input logic [31:0] addr, input logic dirty, input logic [31:0] vaddr,
                             input logic [127:0] vdata, input int extra);
        logic [31:0] base;
        fill_t       f;
        base = addr & 32'hFFFF_FFF0;
        miss_req = 1'b1;
        miss_addr = addr;
        victim_dirty = dirty;
        victim_addr = vaddr;
        victim_data = vdata;
        if (dirty) begin
            for (int i = 0; i < 4; i++)
                beat_exp.push_back('{we: 1'b1, addr: vaddr + 32'(4 * i), wdata: vdata[32*i +: 32]});
        end
        for (int i = 0; i < 4; i++) begin
            beat_exp.push_back('{we: 1'b0, addr: base + 32'(4 * i), wdata: 32'h0});
            f.data[32*i +: 32] = (base + 32'(4 * i)) ^ 32'hA5A5_0000;
        end
        f.addr = base;
        f.cyc  = cyc + (dirty ? 9 : 5) + 32'(extra);
        fill_exp.push_back(f);
    endtask

    task automatic wait_done(input int limit);
        int k;
        for (k = 0; k < limit; k++) begin
            @(negedge clk);
            if (beat_exp.size() == 0 && fill_exp.size() == 0) break;
        end
        if (k == limit) begin
            fail("timeout", $sformatf("%0d beats, %0d fills outstanding",
                                      beat_exp.size(), fill_exp.size()));
            beat_exp.delete();
            fill_exp.delete();
        end
        next_cycle();
        next_cycle();
    endtask

    initial begin
        int unsigned c;
        rst = 1'b1;
        miss_req = 1'b0;
        miss_addr = '0;
        victim_dirty = 1'b0;
        victim_addr = '0;
        victim_data = '0;
        mem_ready = 1'b1;

        // Reset: stall follows miss_req only, nothing else moves
        next_cycle();
        miss_req = 1'b1;
        @(negedge clk);
        check("stall_in_reset", stall, 1'b1);
        check("req_in_reset", mem_req, 1'b0);
        next_cycle();
        rst = 1'b0;
        miss_req = 1'b0;
        @(negedge clk);
        check("rst_stall", stall, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_fill_valid", fill_valid, 1'b0);
        check("rst_fill_addr", fill_addr, 32'h0);
        check("rst_fill_data", fill_data, 128'h0);

        // Clean miss
        next_cycle();
        push_miss(32'h0000_1234, 1'b0, 32'h0, 128'h0, 0);
        @(negedge clk);
        check("stall_miss_cycle", stall, 1'b1);
        next_cycle();
        miss_req = 1'b0;
        @(negedge clk);
        check("clean_first_read", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h1230});
        wait_done(40);

        // Dirty miss: writeback then refill
        next_cycle();
        push_miss(32'h0000_3018, 1'b1, 32'h0000_2000,
                  {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 0);
        next_cycle();
        miss_req = 1'b0;
        victim_dirty = 1'b0;
        wait_done(40);

        // Backpressure on read beat 2 for three cycles
        next_cycle();
        push_miss(32'h0000_4008, 1'b0, 32'h0, 128'h0, 3);
        next_cycle();
        miss_req = 1'b0;
        next_cycle();
        next_cycle();
        mem_ready = 1'b0;
        @(negedge clk);
        check("bp_addr", mem_addr, 32'h4008);
        next_cycle();
        next_cycle();
        next_cycle();
        mem_ready = 1'b1;
        wait_done(40);

        // Inputs ignored while busy; stall held high throughout
        next_cycle();
        push_miss(32'h0000_1234, 1'b0, 32'h0, 128'h0, 0);
        next_cycle();
        miss_addr = 32'h0000_5000;
        victim_dirty = 1'b1;
        victim_addr = 32'h0000_9000;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("busy_stall_c%0d", k), stall, 1'b1);
            next_cycle();
        end
        miss_req = 1'b0;
        victim_dirty = 1'b0;
        @(negedge clk);
        check("busy_stall_drop", stall, 1'b0);
        wait_done(40);

        // Reset in the middle of the refill, then a fresh miss restarts at beat 0
        next_cycle();
        miss_req = 1'b1;
        miss_addr = 32'h0000_6004;
        victim_dirty = 1'b0;
        beat_exp.push_back('{we: 1'b0, addr: 32'h6000, wdata: 32'h0});
        beat_exp.push_back('{we: 1'b0, addr: 32'h6004, wdata: 32'h0});
        next_cycle();
        miss_req = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("abort_beat2_addr", mem_addr, 32'h6008);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("abort_outputs", {mem_req, stall, fill_valid}, 3'b000);
        check("abort_beats_done", beat_exp.size(), 0);
        next_cycle();
        push_miss(32'h0000_6004, 1'b0, 32'h0, 128'h0, 0);
        next_cycle();
        miss_req = 1'b0;
        @(negedge clk);
        check("restart_beat0", {mem_req, mem_addr}, {1'b1, 32'h6000});
        wait_done(40);

        // Back-to-back: second miss accepted the cycle after FILL
        next_cycle();
        push_miss(32'h0000_7008, 1'b0, 32'h0, 128'h0, 0);
        c = cyc;
        next_cycle();
        miss_req = 1'b0;
        while (cyc < c + 5) next_cycle();
        @(negedge clk);
        check("b2b_first_fill", fill_valid, 1'b1);
        next_cycle();
        push_miss(32'h0000_801C, 1'b0, 32'h0, 128'h0, 0);
        next_cycle();
        miss_req = 1'b0;
        @(negedge clk);
        check("b2b_first_beat", {mem_req, mem_addr}, {1'b1, 32'h8010});
        wait_done(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
